// File: rtl/ooo_slot_alloc_free_if.sv
// Dispatch / release bus of the slot allocator.
// master: dispatch and completion logic. slave: the allocator itself.
interface ooo_slot_alloc_free_if #(
  parameter int els_p = 8
);
  localparam int id_width_lp  = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic                    alloc_v_i;
  logic                    alloc_ready_o;
  logic [els_p-1:0]        alloc_one_hot_o;
  logic [id_width_lp-1:0]  alloc_id_o;
  logic [els_p-1:0]        free_v_i;
  logic                    flush_i;
  logic [els_p-1:0]        busy_o;
  logic [cnt_width_lp-1:0] free_count_o;
  logic                    full_o;
  logic                    empty_o;
  logic                    error_o;

  modport master (
    output alloc_v_i, free_v_i, flush_i,
    input  alloc_ready_o, alloc_one_hot_o, alloc_id_o,
           busy_o, free_count_o, full_o, empty_o, error_o
  );

  modport slave (
    input  alloc_v_i, free_v_i, flush_i,
    output alloc_ready_o, alloc_one_hot_o, alloc_id_o,
           busy_o, free_count_o, full_o, empty_o, error_o
  );
endinterface

// File: rtl/ooo_slot_alloc_free.sv
// Slot allocator / release tracker for issue-queue and ROB slot pools.
// Holds a busy vector, offers the priority free slot (one-hot + index),
// takes it on a valid/ready handshake and recycles multi-hot frees.
module ooo_slot_alloc_free #(
  parameter int els_p      = 8,
  parameter int lo_to_hi_p = 1
) (
  input logic                  clk_i,
  input logic                  reset_i,
  ooo_slot_alloc_free_if.slave bus
);
  localparam int id_width_lp  = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [cnt_width_lp-1:0] els_cnt_lp = cnt_width_lp'(els_p);

  // Number of set bits in a slot vector, sized to the free counter.
  function automatic logic [cnt_width_lp-1:0] popcount(input logic [els_p-1:0] v);
    logic [cnt_width_lp-1:0] n;
    n = '0;
    for (int i = 0; i < els_p; i++) begin
      n = n + cnt_width_lp'(v[i]);
    end
    return n;
  endfunction

  // Bit-reverse a slot vector so one isolation circuit serves both priorities.
  function automatic logic [els_p-1:0] reverse(input logic [els_p-1:0] v);
    logic [els_p-1:0] r;
    for (int i = 0; i < els_p; i++) begin
      r[i] = v[els_p-1-i];
    end
    return r;
  endfunction

  logic [els_p-1:0]        busy_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    err_r;

  logic [els_p-1:0]        cand;
  logic [els_p-1:0]        cand_ord;
  logic [els_p-1:0]        iso_ord;
  logic [els_p-1:0]        one_hot;
  logic [id_width_lp-1:0]  id;
  logic                    ready;
  logic                    fire;
  logic [els_p-1:0]        eff_free;
  logic                    bad_free;
  logic [els_p-1:0]        busy_next;
  logic [cnt_width_lp-1:0] count_next;

  // Priority select from the registered busy vector only (no free bypass).
  always_comb begin
    cand = ~busy_r;
    if (lo_to_hi_p != 0) begin
      cand_ord = cand;
    end else begin
      cand_ord = reverse(cand);
    end
    // Lowest set bit of the ordered candidate vector.
    iso_ord = cand_ord & (~cand_ord + {{(els_p-1){1'b0}}, 1'b1});
    if (lo_to_hi_p != 0) begin
      one_hot = iso_ord;
    end else begin
      one_hot = reverse(iso_ord);
    end
    id = '0;
    for (int i = 0; i < els_p; i++) begin
      id = id | ({id_width_lp{one_hot[i]}} & id_width_lp'(i));
    end
    ready = |cand;
  end

  // Next-state: handshake, filtered frees and free-count bookkeeping.
  always_comb begin
    fire       = bus.alloc_v_i & ready;
    eff_free   = bus.free_v_i & busy_r;
    bad_free   = |(bus.free_v_i & ~busy_r);
    busy_next  = (busy_r & ~eff_free) | (one_hot & {els_p{fire}});
    count_next = count_r - cnt_width_lp'(fire) + popcount(eff_free);
  end

  // State registers; flush releases everything and skips the error check.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_r  <= '0;
      count_r <= els_cnt_lp;
      err_r   <= 1'b0;
    end else if (bus.flush_i) begin
      busy_r  <= '0;
      count_r <= els_cnt_lp;
      err_r   <= err_r;
    end else begin
      busy_r  <= busy_next;
      count_r <= count_next;
      err_r   <= err_r | bad_free;
    end
  end

  assign bus.alloc_ready_o   = ready;
  assign bus.alloc_one_hot_o = one_hot;
  assign bus.alloc_id_o      = id;
  assign bus.busy_o          = busy_r;
  assign bus.free_count_o    = count_r;
  assign bus.full_o          = (count_r == {cnt_width_lp{1'b0}});
  assign bus.empty_o         = (count_r == els_cnt_lp);
  assign bus.error_o         = err_r;
endmodule

// File: tb/tb_ooo_slot_alloc_free.sv
// Bench for ooo_slot_alloc_free: directed vector table, hand sequences for
// the multi-cycle corners, and randomized traffic against a slot-set model.
module tb_ooo_slot_alloc_free;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ooo_slot_alloc_free_if #(.els_p(N)) bus_lo ();
  ooo_slot_alloc_free_if #(.els_p(N)) bus_hi ();

  ooo_slot_alloc_free #(.els_p(N), .lo_to_hi_p(1)) u_lo (.clk_i(clk), .reset_i(rst), .bus(bus_lo));
  ooo_slot_alloc_free #(.els_p(N), .lo_to_hi_p(0)) u_hi (.clk_i(clk), .reset_i(rst), .bus(bus_hi));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-DUT set of busy slots -------------
  bit mb [2][N];
  bit me [2];

  function automatic int msel(input int d);
    if (d == 0) begin
      for (int i = 0; i < N; i++) if (!mb[d][i]) return i;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (!mb[d][i]) return i;
    end
    return -1;
  endfunction

  function automatic int mfree(input int d);
    int n = 0;
    for (int i = 0; i < N; i++) if (!mb[d][i]) n++;
    return n;
  endfunction

  function automatic int mvec(input int d);
    int v = 0;
    for (int i = 0; i < N; i++) if (mb[d][i]) v += (1 << i);
    return v;
  endfunction

  task automatic mclear();
    for (int d = 0; d < 2; d++) begin
      me[d] = 1'b0;
      for (int i = 0; i < N; i++) mb[d][i] = 1'b0;
    end
  endtask

  task automatic mstep(input int d, input bit av, input logic [N-1:0] fv, input bit fl);
    int s;
    s = msel(d);
    if (fl) begin
      for (int i = 0; i < N; i++) mb[d][i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (fv[i]) begin
          if (mb[d][i]) mb[d][i] = 1'b0;
          else me[d] = 1'b1;
        end
      end
      if (av && s >= 0) mb[d][s] = 1'b1;
    end
  endtask

  task automatic mcheck(input int d, input string tag);
    int busy, cnt, err, rdy, id, oh, full, empty, s, ecnt;
    if (d == 0) begin
      busy = int'(bus_lo.busy_o); cnt = int'(bus_lo.free_count_o); err = int'(bus_lo.error_o);
      rdy = int'(bus_lo.alloc_ready_o); id = int'(bus_lo.alloc_id_o); oh = int'(bus_lo.alloc_one_hot_o);
      full = int'(bus_lo.full_o); empty = int'(bus_lo.empty_o);
    end else begin
      busy = int'(bus_hi.busy_o); cnt = int'(bus_hi.free_count_o); err = int'(bus_hi.error_o);
      rdy = int'(bus_hi.alloc_ready_o); id = int'(bus_hi.alloc_id_o); oh = int'(bus_hi.alloc_one_hot_o);
      full = int'(bus_hi.full_o); empty = int'(bus_hi.empty_o);
    end
    s    = msel(d);
    ecnt = mfree(d);
    chk({tag, ".busy"},  busy,  mvec(d));
    chk({tag, ".count"}, cnt,   ecnt);
    chk({tag, ".error"}, err,   int'(me[d]));
    chk({tag, ".ready"}, rdy,   (s >= 0) ? 1 : 0);
    chk({tag, ".id"},    id,    (s >= 0) ? s : 0);
    chk({tag, ".onehot"}, oh,   (s >= 0) ? (1 << s) : 0);
    chk({tag, ".full"},  full,  (ecnt == 0) ? 1 : 0);
    chk({tag, ".empty"}, empty, (ecnt == N) ? 1 : 0);
  endtask

  // ---------------- helpers ------------------------------------------------
  task automatic idle_inputs();
    bus_lo.alloc_v_i = 1'b0; bus_lo.free_v_i = '0; bus_lo.flush_i = 1'b0;
    bus_hi.alloc_v_i = 1'b0; bus_hi.free_v_i = '0; bus_hi.flush_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mclear();
  endtask

  task automatic lo_cycle(input bit av, input logic [N-1:0] fv, input bit fl);
    @(negedge clk);
    bus_lo.alloc_v_i = av; bus_lo.free_v_i = fv; bus_lo.flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic           av;
    logic [N-1:0]   fv;
    logic           fl;
    logic [N-1:0]   eb;
    int             ec;
    logic           ee;
    logic           er;
    int             eid;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //           av    free     fl    busy     cnt err   rdy   id
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0001, 3, 1'b0, 1'b1, 1};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0011, 2, 1'b0, 1'b1, 2};
    vecs[2]  = '{1'b1, 4'b0000, 1'b0, 4'b0111, 1, 1'b0, 1'b1, 3};
    vecs[3]  = '{1'b1, 4'b0000, 1'b0, 4'b1111, 0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 4'b0100, 1'b0, 4'b1011, 1, 1'b0, 1'b1, 2};  // full: free only
    vecs[5]  = '{1'b1, 4'b0000, 1'b0, 4'b1111, 0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 4'b1010, 1'b0, 4'b0101, 2, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b1, 4'b0001, 1'b0, 4'b0110, 2, 1'b0, 1'b1, 0};  // alloc + free
    vecs[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0010, 3, 1'b0, 1'b1, 0};
    vecs[9]  = '{1'b1, 4'b0000, 1'b0, 4'b0011, 2, 1'b0, 1'b1, 2};
    vecs[10] = '{1'b0, 4'b1001, 1'b0, 4'b0010, 3, 1'b1, 1'b1, 0};  // bad free
    vecs[11] = '{1'b1, 4'b0000, 1'b0, 4'b0011, 2, 1'b1, 1'b1, 2};  // error sticky
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4, 1'b1, 1'b1, 0};  // flush wins

    idle_inputs();
    do_reset();
    mcheck(0, "reset_lo");
    mcheck(1, "reset_hi");

    // Directed table on the low-priority instance.
    for (int k = 0; k < 13; k++) begin
      lo_cycle(vecs[k].av, vecs[k].fv, vecs[k].fl);
      chk($sformatf("vec%0d.busy", k),  int'(bus_lo.busy_o),        int'(vecs[k].eb));
      chk($sformatf("vec%0d.count", k), int'(bus_lo.free_count_o),  vecs[k].ec);
      chk($sformatf("vec%0d.error", k), int'(bus_lo.error_o),       int'(vecs[k].ee));
      chk($sformatf("vec%0d.ready", k), int'(bus_lo.alloc_ready_o), int'(vecs[k].er));
      chk($sformatf("vec%0d.id", k),    int'(bus_lo.alloc_id_o),    vecs[k].eid);
      chk($sformatf("vec%0d.onehot", k), int'(bus_lo.alloc_one_hot_o), vecs[k].er ? (1 << vecs[k].eid) : 0);
      chk($sformatf("vec%0d.full", k),  int'(bus_lo.full_o),  (vecs[k].ec == 0) ? 1 : 0);
      chk($sformatf("vec%0d.empty", k), int'(bus_lo.empty_o), (vecs[k].ec == N) ? 1 : 0);
    end
    @(negedge clk);
    idle_inputs();

    // High-priority instance: ids 3 then 2, then flush with a live request.
    @(negedge clk);
    bus_hi.alloc_v_i = 1'b1;
    #1 chk("hi.first_id", int'(bus_hi.alloc_id_o), 3);
    @(posedge clk); #1;
    chk("hi.busy1", int'(bus_hi.busy_o), 4'b1000);
    @(negedge clk);
    #1 chk("hi.second_id", int'(bus_hi.alloc_id_o), 2);
    @(posedge clk); #1;
    chk("hi.busy2", int'(bus_hi.busy_o), 4'b1100);
    @(negedge clk);
    bus_hi.flush_i = 1'b1;
    #1 chk("hi.preflush_id", int'(bus_hi.alloc_id_o), 1);
    @(posedge clk); #1;
    chk("hi.flush_busy",  int'(bus_hi.busy_o), 0);
    chk("hi.flush_count", int'(bus_hi.free_count_o), 4);
    chk("hi.flush_empty", int'(bus_hi.empty_o), 1);
    @(negedge clk);
    idle_inputs();

    // Asynchronous reset between edges while busy=1011 with error set.
    do_reset();
    for (int k = 0; k < 4; k++) lo_cycle(1'b1, 4'b0000, 1'b0);
    lo_cycle(1'b0, 4'b0100, 1'b0);
    lo_cycle(1'b0, 4'b0100, 1'b0);
    chk("pre_async.busy",  int'(bus_lo.busy_o), 4'b1011);
    chk("pre_async.error", int'(bus_lo.error_o), 1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async.busy",  int'(bus_lo.busy_o), 0);
    chk("async.count", int'(bus_lo.free_count_o), 4);
    chk("async.error", int'(bus_lo.error_o), 0);
    chk("async.id",    int'(bus_lo.alloc_id_o), 0);
    @(negedge clk);
    rst = 1'b0;
    mclear();
    lo_cycle(1'b1, 4'b0000, 1'b0);
    chk("post_reset.first_alloc", int'(bus_lo.busy_o), 4'b0001);
    @(negedge clk);
    idle_inputs();

    // Randomized traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit av [2];
      logic [N-1:0] fv [2];
      bit fl [2];
      @(negedge clk);
      mcheck(0, "rnd_lo");
      mcheck(1, "rnd_hi");
      for (int d = 0; d < 2; d++) begin
        logic [N-1:0] bm;
        bm    = N'(mvec(d));
        av[d] = ($urandom_range(0, 9) < 7);
        fv[d] = N'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) fv[d] = fv[d] & N'($urandom_range(0, 15));
        if ($urandom_range(0, 19) != 0) fv[d] = fv[d] & bm;
        fl[d] = ($urandom_range(0, 49) == 0);
      end
      bus_lo.alloc_v_i = av[0]; bus_lo.free_v_i = fv[0]; bus_lo.flush_i = fl[0];
      bus_hi.alloc_v_i = av[1]; bus_hi.free_v_i = fv[1]; bus_hi.flush_i = fl[1];
      @(posedge clk);
      mstep(0, av[0], fv[0], fl[0]);
      mstep(1, av[1], fv[1], fl[1]);
      if (c % 500 == 499) begin
        // Error is sticky; occasionally reset so the flag gets re-observed.
        do_reset();
      end
    end
    @(negedge clk);
    mcheck(0, "final_lo");
    mcheck(1, "final_hi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
